// File: rtl/pipe_serializer_pkg.sv
// Shared types and helpers for the pipe_serializer word-to-chunk narrowing stage.
package pipe_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_ELS   = 4;

  // Counter width for an els-chunk word; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned els);
    return (els < 2) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/pipe_serializer_chunk_counter.sv
// Modulo-els_p chunk index counter; wraps to zero after the last chunk.
module ser_chunk_counter
  import pipe_serializer_pkg::*;
#(
  parameter int unsigned els_p = DEF_ELS,
  parameter int unsigned cnt_w = cnt_width(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [cnt_w-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [cnt_w-1:0] LAST_IDX = cnt_w'(els_p - 1);

  logic [cnt_w-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST_IDX);
  assign cnt_o  = cnt_q;

  // Clear wins over enable so a last-chunk reload always restarts at chunk 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_serializer.sv
// Accepts a width_p word on valid/yumi and emits els_p chunks on valid/ready, back-to-back.
module pipe_serializer
  import pipe_serializer_pkg::*;
#(
  parameter int unsigned width_p     = DEF_WIDTH,
  parameter int unsigned els_p       = DEF_ELS,
  parameter bit          msb_first_p = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  output logic                       valid_o,
  output logic [width_p/els_p-1:0]   data_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int unsigned chunk_w = width_p / els_p;
  localparam int unsigned cnt_w   = cnt_width(els_p);

  if (((width_p % els_p) != 0) || (els_p < 2)) begin : g_bad_params
    $error("pipe_serializer: width_p must be a multiple of els_p and els_p must be >= 2");
  end

  ser_state_e         state_q, state_d;
  logic [width_p-1:0] shift_q, shift_d;
  logic [cnt_w-1:0]   cnt;
  logic               cnt_last;
  logic               cnt_en, cnt_clr;
  logic               load;
  logic               yumi;

  ser_chunk_counter #(
    .els_p (els_p),
    .cnt_w (cnt_w)
  ) u_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .cnt_o     (cnt),
    .last_o    (cnt_last)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    yumi    = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          yumi    = 1'b1;
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (!cnt_last) begin
            cnt_en = 1'b1;
          end else begin
            yumi    = valid_i;
            cnt_clr = 1'b1;
            if (valid_i) load    = 1'b1;
            else         state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_d = load ? data_i : shift_q;

  // NOTE: the word register is a plain flop bank, so it is reset like any other state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  // The held word is never shifted; the counter selects which slice is presented.
  logic [chunk_w-1:0] chunks [els_p];
  logic [cnt_w-1:0]   sel;

  always_comb begin
    for (int i = 0; i < int'(els_p); i++) begin
      chunks[i] = shift_q[i*chunk_w +: chunk_w];
    end
  end

  assign sel     = msb_first_p ? (cnt_w'(els_p - 1) - cnt) : cnt;
  assign data_o  = chunks[sel];
  assign valid_o = (state_q == SEND);
  assign last_o  = valid_o & cnt_last;
  assign yumi_o  = yumi & reset_n_i;

endmodule
